// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the three-port SDRAM command arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    P_WR,
    P_RD1,
    P_RD2
  } port_t;

  localparam int DEFAULT_AW      = 25;
  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic is_read(port_t p);
    return p != P_WR;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Grant selection: the download writer always wins, and the two readers alternate on a tie.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic  wr_req,
  input  logic  rd1_req,
  input  logic  rd2_req,
  input  port_t last_rd,
  output logic  valid,
  output port_t grant
);

  always_comb begin
    valid = wr_req | rd1_req | rd2_req;
    grant = P_WR;
    if (wr_req) begin
      grant = P_WR;
    end else if (rd1_req && rd2_req) begin
      // On a tie, the reader that did not win last time is served.
      grant = (last_rd == P_RD1) ? P_RD2 : P_RD1;
    end else if (rd1_req) begin
      grant = P_RD1;
    end else if (rd2_req) begin
      grant = P_RD2;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Three-port arbiter multiplexing the download writer, cassette and cartridge
// readers onto the single-byte SDRAM controller, with a watchdog on each command.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ack,
  input  logic          rd1_req,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_ack,
  output logic [7:0]    rd1_data,
  input  logic          rd2_req,
  input  logic [AW-1:0] rd2_addr,
  output logic          rd2_ack,
  output logic [7:0]    rd2_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ready,
  output logic          busy,
  output logic          timeout_err
);

  localparam int            CW      = $clog2(TIMEOUT + 2) + 1;
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
  localparam bit            WDOG_ON = (TIMEOUT != 0);

  state_t        state;
  port_t         owner;
  port_t         last_rd;
  logic [CW-1:0] age;

  logic          pick_valid;
  port_t         pick_grant;
  logic [AW-1:0] pick_addr;
  logic          done;
  logic [7:0]    result;

  sdram_arb_pick u_pick (
    .wr_req  (wr_req),
    .rd1_req (rd1_req),
    .rd2_req (rd2_req),
    .last_rd (last_rd),
    .valid   (pick_valid),
    .grant   (pick_grant)
  );

  always_comb begin
    pick_addr = wr_addr;
    case (pick_grant)
      P_RD1:   pick_addr = rd1_addr;
      P_RD2:   pick_addr = rd2_addr;
      default: pick_addr = wr_addr;
    endcase
  end

  // age counts cycles since the request was sampled, so the abort lands at
  // the same cycle offset a controller answer would; mem_ready always wins.
  always_comb begin
    done   = (state == WAIT) && (mem_ready || (WDOG_ON && age >= LIMIT));
    result = mem_ready ? mem_dout : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= P_WR;
      last_rd     <= P_RD2;
      age         <= '0;
      busy        <= 1'b0;
      wr_ack      <= 1'b0;
      rd1_ack     <= 1'b0;
      rd2_ack     <= 1'b0;
      rd1_data    <= 8'h00;
      rd2_data    <= 8'h00;
      mem_addr    <= '0;
      mem_din     <= 8'h00;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_ack      <= 1'b0;
      rd1_ack     <= 1'b0;
      rd2_ack     <= 1'b0;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_grant;
            mem_addr <= pick_addr;
            if (is_read(pick_grant)) begin
              mem_rd  <= 1'b1;
              last_rd <= pick_grant;
            end else begin
              mem_we  <= 1'b1;
              mem_din <= wr_data;
            end
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end

        ISSUE: begin
          age   <= CW'(2);
          state <= WAIT;
        end

        WAIT: begin
          if (done) begin
            case (owner)
              P_RD1: begin
                rd1_ack  <= 1'b1;
                rd1_data <= result;
              end
              P_RD2: begin
                rd2_ack  <= 1'b1;
                rd2_data <= result;
              end
              default: wr_ack <= 1'b1;
            endcase
            timeout_err <= ~mem_ready;
            state       <= IDLE;
            busy        <= 1'b0;
          end else if (WDOG_ON) begin
            age <= age + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: a latency-programmable controller model plus
// per-port expected-completion queues and an optional grant-order queue.
module tb_sdram_arb;
  import sdram_arb_pkg::*;

  localparam int AW  = 25;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ack;
  logic          rd1_req = 1'b0;
  logic [AW-1:0] rd1_addr = '0;
  logic          rd1_ack;
  logic [7:0]    rd1_data;
  logic          rd2_req = 1'b0;
  logic [AW-1:0] rd2_addr = '0;
  logic          rd2_ack;
  logic [7:0]    rd2_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_rd;
  logic          mem_we;
  logic [7:0]    mem_dout = 8'hEE;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  sdram_arb #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd1_req     (rd1_req),
    .rd1_addr    (rd1_addr),
    .rd1_ack     (rd1_ack),
    .rd1_data    (rd1_data),
    .rd2_req     (rd2_req),
    .rd2_addr    (rd2_addr),
    .rd2_ack     (rd2_ack),
    .rd2_data    (rd2_data),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Controller model: answers each strobe after lat cycles unless hang is set.
  int            lat = 3;
  bit            hang = 1'b0;
  int            ctl_cnt = 0;
  logic [AW-1:0] ctl_addr = '0;
  logic [7:0]    mem_model [logic [AW-1:0]];

  function automatic logic [7:0] fill(logic [AW-1:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_dout  = 8'hEE;
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        mem_ready = 1'b1;
        mem_dout  = mem_model.exists(ctl_addr) ? mem_model[ctl_addr] : fill(ctl_addr);
      end
    end
    if ((mem_rd || mem_we) && !hang) begin
      ctl_cnt  = lat;
      ctl_addr = mem_addr;
      if (mem_we) mem_model[mem_addr] = mem_din;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    int         cyc;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  exp_t          q2[$];
  int            ord_q[$];
  int            reraise[3] = '{0, 0, 0};
  bit            pend[3] = '{0, 0, 0};
  logic [AW-1:0] raddr[3];
  logic [7:0]    rexp[3];

  task automatic applyStimulus(int p, logic [AW-1:0] a, logic [7:0] d,
                               logic [7:0] expd, logic tmo, int ecyc);
    exp_t e;
    e.data = expd;
    e.tmo  = tmo;
    e.cyc  = ecyc;
    raddr[p] = a;
    rexp[p]  = expd;
    case (p)
      0: begin wr_addr = a; wr_data = d; wr_req = 1'b1; q0.push_back(e); end
      1: begin rd1_addr = a; rd1_req = 1'b1; q1.push_back(e); end
      2: begin rd2_addr = a; rd2_req = 1'b1; q2.push_back(e); end
      default: ;
    endcase
  endtask

  task automatic popExp(int p, output exp_t e, output bit ok);
    ok = 1'b0;
    e.data = 8'h00; e.tmo = 1'b0; e.cyc = -1;
    case (p)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic dropReq(int p);
    case (p)
      0: wr_req = 1'b0;
      1: rd1_req = 1'b0;
      2: rd2_req = 1'b0;
      default: ;
    endcase
  endtask

  // Completion monitor: clients drop req in the ack cycle and optionally re-raise next cycle.
  initial begin : monitor
    exp_t       e;
    bit         ok;
    logic [2:0] acks;
    logic [7:0] dat;
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++) begin
        if (pend[p]) begin
          pend[p] = 1'b0;
          applyStimulus(p, raddr[p], 8'h00, rexp[p], 1'b0, -1);
        end
      end
      acks = {rd2_ack, rd1_ack, wr_ack};
      if (timeout_err && acks == 3'b000) checkOutput("timeout_without_ack", 32'(timeout_err), 32'd0);
      for (int p = 0; p < 3; p++) begin
        if (acks[p]) begin
          popExp(p, e, ok);
          if (!ok) begin
            checkOutput($sformatf("spurious_ack%0d", p), 32'd1, 32'd0);
          end else begin
            if (p != 0) begin
              dat = (p == 1) ? rd1_data : rd2_data;
              checkOutput($sformatf("rd%0d_data", p), 32'(dat), 32'(e.data));
            end
            checkOutput($sformatf("timeout_err_port%0d", p), 32'(timeout_err), 32'(e.tmo));
            if (e.cyc >= 0) checkOutput($sformatf("ack%0d_cycle", p), 32'(cyc), 32'(e.cyc));
          end
          if (ord_q.size() > 0) checkOutput("grant_order", 32'(p), 32'(ord_q.pop_front()));
          dropReq(p);
          if (reraise[p] > 0) begin
            reraise[p]--;
            pend[p] = 1'b1;
          end
        end
      end
    end
  end

  task automatic waitDrain(int budget);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 || pend[0] || pend[1] || pend[2]) begin
      if (n >= budget) begin
        checkOutput("drain_timeout", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        q0.delete(); q1.delete(); q2.delete(); ord_q.delete();
        for (int p = 0; p < 3; p++) begin
          pend[p] = 1'b0;
          reraise[p] = 0;
          dropReq(p);
        end
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  int n;

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acks", 32'({wr_ack, rd1_ack, rd2_ack}), 32'd0);
    checkOutput("rst_strobes", 32'({mem_rd, mem_we}), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_din", 32'(mem_din), 32'd0);
    checkOutput("rst_rd_data", 32'({rd1_data, rd2_data}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single write");
    n = cyc;
    applyStimulus(0, 25'h000123, 8'hA5, 8'h00, 1'b0, n + 2 + lat);
    @(posedge clk); #1;
    checkOutput("wr_strobe_we", 32'(mem_we), 32'd1);
    checkOutput("wr_strobe_rd", 32'(mem_rd), 32'd0);
    checkOutput("wr_mem_addr", 32'(mem_addr), 32'h123);
    checkOutput("wr_mem_din", 32'(mem_din), 32'hA5);
    checkOutput("wr_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("wr_we_one_cycle", 32'(mem_we), 32'd0);
    checkOutput("wr_addr_hold", 32'(mem_addr), 32'h123);
    waitDrain(40);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] single read");
    mem_model[25'h000040] = 8'h3C;
    n = cyc;
    applyStimulus(1, 25'h000040, 8'h00, 8'h3C, 1'b0, n + 2 + lat);
    waitDrain(40);
    checkOutput("rd2_data_unchanged", 32'(rd2_data), 32'd0);

    $display("[TB] read back written byte");
    lat = 2;
    n = cyc;
    applyStimulus(2, 25'h000123, 8'h00, 8'hA5, 1'b0, n + 2 + lat);
    waitDrain(40);

    $display("[TB] watchdog abort");
    hang = 1'b1;
    n = cyc;
    applyStimulus(2, 25'h000077, 8'h00, 8'hFF, 1'b1, n + 1 + TMO);
    waitDrain(40);
    hang = 1'b0;

    $display("[TB] mem_ready on the timeout cycle");
    lat = TMO - 1;
    n = cyc;
    applyStimulus(2, 25'h000078, 8'h00, fill(25'h000078), 1'b0, n + 1 + TMO);
    waitDrain(40);

    $display("[TB] reset while waiting");
    lat = 6;
    n = cyc;
    applyStimulus(1, 25'h000055, 8'h00, fill(25'h000055), 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    rd1_req = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rd1_data", 32'(rd1_data), 32'd0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("late_ready_ignored", 32'(busy), 32'd0);
    lat = 3;
    n = cyc;
    applyStimulus(1, 25'h000056, 8'h00, fill(25'h000056), 1'b0, n + 2 + lat);
    waitDrain(40);

    $display("[TB] contention after reset");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ord_q.push_back(0);
    for (int i = 0; i < 3; i++) begin
      ord_q.push_back(1);
      ord_q.push_back(2);
    end
    reraise[1] = 2;
    reraise[2] = 2;
    applyStimulus(0, 25'h000200, 8'h11, 8'h00, 1'b0, -1);
    applyStimulus(1, 25'h000201, 8'h00, fill(25'h000201), 1'b0, -1);
    applyStimulus(2, 25'h000202, 8'h00, fill(25'h000202), 1'b0, -1);
    waitDrain(300);
    checkOutput("contention_order_left", 32'(ord_q.size()), 32'd0);

    $display("[TB] writer pre-empts round robin");
    ord_q.push_back(1);
    ord_q.push_back(0);
    ord_q.push_back(2);
    ord_q.push_back(1);
    ord_q.push_back(2);
    reraise[1] = 1;
    reraise[2] = 1;
    applyStimulus(1, 25'h000301, 8'h00, fill(25'h000301), 1'b0, -1);
    applyStimulus(2, 25'h000302, 8'h00, fill(25'h000302), 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(0, 25'h000300, 8'h22, 8'h00, 1'b0, -1);
    waitDrain(300);
    checkOutput("preempt_order_left", 32'(ord_q.size()), 32'd0);

    n = cyc;
    applyStimulus(1, 25'h000300, 8'h00, 8'h22, 1'b0, n + 2 + lat);
    waitDrain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "[TB] global timeout");
  end

endmodule
